// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  localparam int DIV_WIDTH_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_r_next,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_rs;
  logic [WIDTH:0] w_t;
  logic           w_borrow;
  logic           w_unused_top;

  assign w_rs = {i_r, i_q_msb};
  assign {w_borrow, w_t} = {1'b0, w_rs} - {2'b00, i_divisor};
  assign o_q_bit = ~w_borrow;
  // R < divisor is invariant, so the top bit is always zero here
  assign o_r_next = o_q_bit ? w_t[WIDTH-1:0] : w_rs[WIDTH-1:0];
  assign w_unused_top = w_t[WIDTH] ^ w_rs[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// DIV_ZERO_FLAG_EN: flag zero divisors and finish them in one cycle.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] w_rn;
  logic             w_qb;
  logic             w_accept;
  logic             w_skip;
  logic             w_last;

  assign busy     = (r_state == CALC);
  assign w_accept = (r_state == IDLE) & start;
  assign w_last   = (r_cnt == CW'(1));

`ifdef DIV_ZERO_FLAG_EN
  logic r_dz;
  assign w_skip      = w_accept & (divisor == '0);
  assign div_by_zero = r_dz;
`else
  assign w_skip      = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r      (r_rem),
    .i_q_msb  (r_quo[WIDTH-1]),
    .i_divisor(r_div),
    .o_r_next (w_rn),
    .o_q_bit  (w_qb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept && !w_skip) w_next = CALC;
      CALC: if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      r_dz      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_div <= divisor;
        r_rem <= '0;
        r_quo <= dividend;
        r_cnt <= CW'(WIDTH);
`ifdef DIV_ZERO_FLAG_EN
        if (w_skip) begin
          r_cnt     <= '0;
          done      <= 1'b1;
          quotient  <= '1;
          remainder <= dividend;
          r_dz      <= 1'b1;
        end
`endif
      end else if (busy) begin
        r_rem <= w_rn;
        r_quo <= {r_quo[WIDTH-2:0], w_qb};
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          done      <= 1'b1;
          quotient  <= {r_quo[WIDTH-2:0], w_qb};
          remainder <= w_rn;
`ifdef DIV_ZERO_FLAG_EN
          r_dz      <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and swept checks of seq_restoring_divider against an arithmetic model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk = 0;
  int n_fail = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: results by plain division, timing as a countdown of edges.
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic         e_busy = 0, e_done = 0, e_dz = 0;
  logic [W-1:0] e_q = '0, e_r = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; e_busy = 0; e_done = 0;
      e_q = '0; e_r = '0; e_dz = 0;
    end else begin
      e_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          e_done = 1; e_q = m_q; e_r = m_r; e_dz = 0;
        end
      end else if (start) begin
        m_q = (divisor == 0) ? '1 : W'(dividend / divisor);
        m_r = (divisor == 0) ? dividend : W'(dividend % divisor);
        m_left = W;
`ifdef DIV_ZERO_FLAG_EN
        if (divisor == 0) begin
          m_left = 0; e_done = 1; e_q = m_q; e_r = m_r; e_dz = 1;
        end
`endif
      end
      e_busy = (m_left > 0);
    end
  end

  always @(negedge clk) begin
    chk("m_busy", busy, e_busy);
    chk("m_done", done, e_done);
    chk("m_quot", quotient, e_q);
    chk("m_rem", remainder, e_r);
    chk("m_dz", div_by_zero, e_dz);
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input int lat, input logic [W-1:0] eq,
                    input logic [W-1:0] er, input logic edz,
                    input int poke, input bit chain);
    int cyc;
    int bsy;
    cyc = 0;
    bsy = 0;
    if (!chain) @(negedge clk);
    #1;
    start = 1; dividend = a; divisor = b;
    do begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (busy) bsy++;
      #1;
      start = (cyc == poke);
      if (cyc == poke) begin
        dividend = 9; divisor = 2;
      end
    end while (cyc < 40);
    chk("latency", cyc, lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    if (lat > 1) chk("busy_cycles", bsy, lat - 1);
    #1;
    start = 0;
  endtask

  initial begin
    int a;
    int b;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    #1 rst = 0;

    op(100, 7, 9, 14, 2, 0, 0, 0);
    op(255, 1, 9, 255, 0, 0, 0, 0);
    op(5, 9, 9, 0, 5, 0, 0, 0);
    op(255, 255, 9, 1, 0, 0, 0, 0);
    op(0, 3, 9, 0, 0, 0, 0, 0);
`ifdef DIV_ZERO_FLAG_EN
    op(37, 0, 1, 255, 37, 1, 0, 0);
`else
    op(37, 0, 9, 255, 37, 0, 0, 0);
`endif
    op(50, 3, 9, 16, 2, 0, 3, 0);
    op(9, 2, 9, 4, 1, 0, 0, 1);

    @(negedge clk);
    #1;
    start = 1; dividend = 200; divisor = 13;
    repeat (4) begin
      @(negedge clk);
      #1 start = 0;
    end
    rst = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    op(200, 13, 9, 15, 5, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      op(W'(a), W'(b), 9, W'(a / b), W'(a % b), 0, 0, 0);
      chk("identity", int'(quotient) * b + int'(remainder), a);
      chk("rem_lt_div", int'(remainder) < b, 1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
